// File: rtl/add_sequencer.sv
// rtl/add_sequencer.sv - reads two words from memory, adds or subtracts them, writes the result back.
// Memory is synchronous: read data is valid on the edge after the read strobe.
module add_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP_B = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                op_q, op_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic [ADDR_W-1:0]   addr_c_q, addr_c_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                carry_q, carry_d;

    // The extra top bit of the difference is the unsigned borrow.
    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;
    assign sum_w  = {1'b0, op_a_q} + {1'b0, mem_rdata};
    assign diff_w = {1'b0, op_a_q} - {1'b0, mem_rdata};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            op_a_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
            op_a_q   <= op_a_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        addr_c_d    = addr_c_q;
        op_a_d      = op_a_q;
        result_d    = result_q;
        carry_d     = carry_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    addr_a_d = addr_a;
                    addr_b_d = addr_b;
                    addr_c_d = addr_c;
                    state_d  = RD_A;
                end
            end
            RD_A: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                mem_address = addr_a_q;
                state_d     = RD_B;
            end
            RD_B: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                mem_address = addr_b_q;
                op_a_d      = mem_rdata;
                state_d     = CAP_B;
            end
            CAP_B: begin
                busy = 1'b1;
                if (op_q) begin
                    result_d = diff_w[DATA_W-1:0];
                    carry_d  = diff_w[DATA_W];
                end else begin
                    result_d = sum_w[DATA_W-1:0];
                    carry_d  = sum_w[DATA_W];
                end
                state_d = WR;
            end
            WR: begin
                busy        = 1'b1;
                mem_write   = 1'b1;
                mem_address = addr_c_q;
                mem_wdata   = result_q;
                state_d     = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = result_q;
    assign carry  = carry_q;

endmodule
